fifo_wr_arbiter: RTL and testbench

- Round-robin arbiter that shares a single FIFO write port among NREQ requesters.
- Sits in the write-clock domain, in front of the FIFO write side.
- Grants one requester at a time for a burst of up to MAX_BURST beats and honours FIFO-full backpressure.
- Gives the control FSMs on the write side fair, bounded access to the buffer.

---
 rtl/fifo_wr_arbiter.sv | 131 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ requesters.
// Grants bursts of up to MAX_BURST beats and honours FIFO-full backpressure.
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NREQ-1:0]                   req_valid,
    input  logic [NREQ*DW-1:0]                req_data,
    output logic [NREQ-1:0]                   req_ready,
    input  logic                              fifo_full,
    output logic                              fifo_wr_en,
    output logic [DW-1:0]                     fifo_wr_data,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] grant_id,
    output logic                              busy
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int unsigned NR = NREQ;

    typedef enum logic {IDLE, XFER} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [GW-1:0]   sel_hi, sel_lo, sel;
    logic            found_hi, found_lo, found;
    logic            valid_g, xfer;
    logic [DW-1:0]   data_g;
    logic [NREQ-1:0] onehot_g;

    // Rotating priority: first set bit above last_q wins, else first set bit at or below it.
    always_comb begin
        sel_hi   = '0;
        sel_lo   = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        for (int unsigned i = 0; i < NR; i++) begin
            if (req_valid[i]) begin
                if (i > 32'(last_q)) begin
                    if (!found_hi) begin
                        sel_hi   = GW'(i);
                        found_hi = 1'b1;
                    end
                end else if (!found_lo) begin
                    sel_lo   = GW'(i);
                    found_lo = 1'b1;
                end
            end
        end
        found = found_hi | found_lo;
        sel   = found_hi ? sel_hi : sel_lo;
    end

    always_comb begin
        valid_g  = 1'b0;
        data_g   = '0;
        onehot_g = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            if (GW'(i) == grant_q) begin
                valid_g     = req_valid[i];
                data_g      = req_data[i*DW +: DW];
                onehot_g[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = '0;
        req_ready    = '0;
        busy         = 1'b0;
        xfer         = valid_g & ~fifo_full;

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = sel;
                    last_d  = sel;
                    cnt_d   = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                busy         = 1'b1;
                fifo_wr_data = data_g;
                fifo_wr_en   = xfer;
                req_ready    = fifo_full ? '0 : onehot_g;
                // A dropped valid ends the burst even while the FIFO is full.
                if (!valid_g) begin
                    state_d = IDLE;
                end else if (xfer) begin
                    if (cnt_q == CW'(MAX_BURST - 1)) state_d = IDLE;
                    else                             cnt_d   = cnt_q + 1'b1;
                end
            end
        endcase

        if (rst) begin
            fifo_wr_en = 1'b0;
            req_ready  = '0;
            busy       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= GW'(NREQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant_id = grant_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NREQ=4, DW=8, MAX_BURST=4).
// Inputs change 1 time unit after each rising edge; outputs are checked 1 unit later.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wr_data;
    logic [1:0]  grant_id;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    fifo_wr_arbiter #(.NREQ(4), .DW(8), .MAX_BURST(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pk(input logic [7:0] d3, input logic [7:0] d2,
                                       input logic [7:0] d1, input logic [7:0] d0);
        return {d3, d2, d1, d0};
    endfunction

    task automatic cyc(input logic r, input logic [3:0] v, input logic f, input logic [31:0] d);
        @(posedge clk);
        #1;
        rst       = r;
        req_valid = v;
        fifo_full = f;
        req_data  = d;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic en, input logic [7:0] dat,
                              input logic [1:0] gid, input logic [3:0] rdy, input logic bsy);
        chk({tag, " wr_en"},   32'(fifo_wr_en),   32'(en));
        chk({tag, " wr_data"}, 32'(fifo_wr_data), 32'(dat));
        chk({tag, " grant"},   32'(grant_id),     32'(gid));
        chk({tag, " ready"},   32'(req_ready),    32'(rdy));
        chk({tag, " busy"},    32'(busy),         32'(bsy));
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        fifo_full = 1'b0;
        req_data  = '0;

        // Reset state
        cyc(1'b1, 4'b0000, 1'b0, 32'h0);
        expect_out("reset", 1'b0, 8'h00, 2'd0, 4'b0000, 1'b0);

        // Single requester 2, full burst then a second burst
        cyc(1'b0, 4'b0100, 1'b0, pk(8'h00, 8'hA0, 8'h00, 8'h00));
        expect_out("t1 idle", 1'b0, 8'h00, 2'd0, 4'b0000, 1'b0);
        for (int b = 0; b < 4; b++) begin
            cyc(1'b0, 4'b0100, 1'b0, pk(8'h00, 8'hA0 + 8'(b), 8'h00, 8'h00));
            expect_out("t1 beat", 1'b1, 8'hA0 + 8'(b), 2'd2, 4'b0100, 1'b1);
        end
        cyc(1'b0, 4'b0100, 1'b0, pk(8'h00, 8'hA4, 8'h00, 8'h00));
        expect_out("t1 bubble", 1'b0, 8'h00, 2'd2, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0100, 1'b0, pk(8'h00, 8'hA4, 8'h00, 8'h00));
        expect_out("t1 beat A4", 1'b1, 8'hA4, 2'd2, 4'b0100, 1'b1);
        cyc(1'b0, 4'b0100, 1'b0, pk(8'h00, 8'hA5, 8'h00, 8'h00));
        expect_out("t1 beat A5", 1'b1, 8'hA5, 2'd2, 4'b0100, 1'b1);
        cyc(1'b0, 4'b0000, 1'b0, 32'h0);
        expect_out("t1 drop", 1'b0, 8'h00, 2'd2, 4'b0100, 1'b1);
        cyc(1'b0, 4'b0000, 1'b0, 32'h0);
        expect_out("t1 end", 1'b0, 8'h00, 2'd2, 4'b0000, 1'b0);

        // All four continuously valid after reset: rotation 0,1,2,3,0
        cyc(1'b1, 4'b0000, 1'b0, 32'h0);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 4'b1111, 1'b0, pk(8'hB3, 8'hB2, 8'hB1, 8'hB0));
            expect_out("t2 gap", 1'b0, 8'h00, (k == 0) ? 2'd0 : 2'((k - 1) % 4), 4'b0000, 1'b0);
            for (int b = 0; b < 4; b++) begin
                cyc(1'b0, 4'b1111, 1'b0, pk(8'hB3, 8'hB2, 8'hB1, 8'hB0));
                expect_out("t2 beat", 1'b1, 8'hB0 + 8'(k % 4), 2'(k % 4), 4'(1 << (k % 4)), 1'b1);
            end
        end
        cyc(1'b0, 4'b0000, 1'b0, 32'h0);
        expect_out("t2 end", 1'b0, 8'h00, 2'd0, 4'b0000, 1'b0);

        // Requester 1 with three full cycles after beat 2
        cyc(1'b0, 4'b0010, 1'b0, pk(8'h00, 8'h00, 8'hC0, 8'h00));
        expect_out("t3 idle", 1'b0, 8'h00, 2'd0, 4'b0000, 1'b0);
        for (int b = 0; b < 2; b++) begin
            cyc(1'b0, 4'b0010, 1'b0, pk(8'h00, 8'h00, 8'hC0 + 8'(b), 8'h00));
            expect_out("t3 beat", 1'b1, 8'hC0 + 8'(b), 2'd1, 4'b0010, 1'b1);
        end
        for (int s = 0; s < 3; s++) begin
            cyc(1'b0, 4'b0010, 1'b1, pk(8'h00, 8'h00, 8'hC2, 8'h00));
            expect_out("t3 stall", 1'b0, 8'hC2, 2'd1, 4'b0000, 1'b1);
        end
        for (int b = 2; b < 4; b++) begin
            cyc(1'b0, 4'b0010, 1'b0, pk(8'h00, 8'h00, 8'hC0 + 8'(b), 8'h00));
            expect_out("t3 resume", 1'b1, 8'hC0 + 8'(b), 2'd1, 4'b0010, 1'b1);
        end
        cyc(1'b0, 4'b0000, 1'b0, 32'h0);
        expect_out("t3 end", 1'b0, 8'h00, 2'd1, 4'b0000, 1'b0);

        // Requester 3 drops after two beats; requester 0 is next
        cyc(1'b0, 4'b1001, 1'b0, pk(8'hD0, 8'h00, 8'h00, 8'hE0));
        expect_out("t4 idle", 1'b0, 8'h00, 2'd1, 4'b0000, 1'b0);
        cyc(1'b0, 4'b1001, 1'b0, pk(8'hD0, 8'h00, 8'h00, 8'hE0));
        expect_out("t4 beat1", 1'b1, 8'hD0, 2'd3, 4'b1000, 1'b1);
        cyc(1'b0, 4'b1001, 1'b0, pk(8'hD1, 8'h00, 8'h00, 8'hE0));
        expect_out("t4 beat2", 1'b1, 8'hD1, 2'd3, 4'b1000, 1'b1);
        cyc(1'b0, 4'b0001, 1'b0, pk(8'hD2, 8'h00, 8'h00, 8'hE0));
        expect_out("t4 drop", 1'b0, 8'hD2, 2'd3, 4'b1000, 1'b1);
        cyc(1'b0, 4'b0001, 1'b0, pk(8'h00, 8'h00, 8'h00, 8'hE0));
        expect_out("t4 gap", 1'b0, 8'h00, 2'd3, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0001, 1'b0, pk(8'h00, 8'h00, 8'h00, 8'hE0));
        expect_out("t4 next", 1'b1, 8'hE0, 2'd0, 4'b0001, 1'b1);
        cyc(1'b0, 4'b0000, 1'b0, 32'h0);
        expect_out("t4 end", 1'b0, 8'h00, 2'd0, 4'b0001, 1'b1);

        // Reset mid-burst; pointer returns to requester 0 first
        cyc(1'b0, 4'b0100, 1'b0, pk(8'h00, 8'hF0, 8'h00, 8'h00));
        expect_out("t5 idle", 1'b0, 8'h00, 2'd0, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0100, 1'b0, pk(8'h00, 8'hF0, 8'h00, 8'h00));
        expect_out("t5 beat1", 1'b1, 8'hF0, 2'd2, 4'b0100, 1'b1);
        cyc(1'b1, 4'b0100, 1'b0, pk(8'h00, 8'hF1, 8'h00, 8'h00));
        chk("t5 rst wr_en", 32'(fifo_wr_en), 32'd0);
        chk("t5 rst ready", 32'(req_ready), 32'd0);
        chk("t5 rst busy", 32'(busy), 32'd0);
        cyc(1'b0, 4'b0101, 1'b0, pk(8'h00, 8'hF2, 8'h00, 8'hF8));
        expect_out("t5 post", 1'b0, 8'h00, 2'd0, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0101, 1'b0, pk(8'h00, 8'hF2, 8'h00, 8'hF8));
        expect_out("t5 regrant", 1'b1, 8'hF8, 2'd0, 4'b0001, 1'b1);
        cyc(1'b0, 4'b0000, 1'b0, 32'h0);
        expect_out("t5 end", 1'b0, 8'h00, 2'd0, 4'b0001, 1'b1);

        // Full and valid drop in the same cycle
        cyc(1'b0, 4'b0010, 1'b0, pk(8'h00, 8'h00, 8'h77, 8'h00));
        expect_out("t6 idle", 1'b0, 8'h00, 2'd0, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0010, 1'b0, pk(8'h00, 8'h00, 8'h77, 8'h00));
        expect_out("t6 beat", 1'b1, 8'h77, 2'd1, 4'b0010, 1'b1);
        cyc(1'b0, 4'b0000, 1'b1, 32'h0);
        expect_out("t6 drop+full", 1'b0, 8'h00, 2'd1, 4'b0000, 1'b1);
        cyc(1'b0, 4'b0000, 1'b0, 32'h0);
        expect_out("t6 end", 1'b0, 8'h00, 2'd1, 4'b0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
